// File: rtl/semaforo_pkg.sv
// rtl/semaforo_pkg.sv - light codes, FSM state codes and sizing helper shared by the traffic-light stages
package semaforo_pkg;

    localparam logic [1:0] ROJO     = 2'b00;
    localparam logic [1:0] AMARILLO = 2'b01;
    localparam logic [1:0] VERDE    = 2'b10;

    typedef enum logic [1:0] {
        A_VERDE    = 2'b00,
        A_AMARILLO = 2'b01,
        B_VERDE    = 2'b10,
        B_AMARILLO = 2'b11
    } estado_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/contador_fase.sv
// rtl/contador_fase.sv - enable-gated dwell counter with synchronous clear
module contador_fase #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cuenta_o
);

    logic [W-1:0] cuenta_q;

    // Clear wins over enable so a reset or transition zeroes the count even while frozen.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cuenta_q <= '0;
        end else if (en_i) begin
            cuenta_q <= cuenta_q + 1'b1;
        end
    end

    assign cuenta_o = cuenta_q;

endmodule

// File: rtl/semaforo_vehicular.sv
// rtl/semaforo_vehicular.sv - two-road vehicular light FSM with A priority and B request sensor
import semaforo_pkg::*;

module semaforo_vehicular #(
    parameter int T_VERDE_MIN = 4,
    parameter int T_VERDE_MAX = 8,
    parameter int T_VERDE_B   = 4,
    parameter int T_AMARILLO  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       sensor_B,
    output logic [1:0] semaforo_A,
    output logic [1:0] semaforo_B,
    output logic [1:0] fase
);

    localparam int W = $clog2(max4(T_VERDE_MIN, T_VERDE_MAX, T_VERDE_B, T_AMARILLO)) + 1;

    localparam logic [W-1:0] LIM_MIN = W'(T_VERDE_MIN - 1);
    localparam logic [W-1:0] LIM_MAX = W'(T_VERDE_MAX - 1);
    localparam logic [W-1:0] LIM_B   = W'(T_VERDE_B - 1);
    localparam logic [W-1:0] LIM_AM  = W'(T_AMARILLO - 1);

    if (T_VERDE_MIN < 1 || T_VERDE_MAX < 1 || T_VERDE_B < 1 || T_AMARILLO < 1) begin : g_err_min
        $error("semaforo_vehicular: all dwell parameters must be >= 1");
    end
    if (T_VERDE_MIN > T_VERDE_MAX) begin : g_err_orden
        $error("semaforo_vehicular: T_VERDE_MIN must not exceed T_VERDE_MAX");
    end

    estado_t      state_q, state_d;
    logic         avanzar;
    logic [W-1:0] cuenta;

    contador_fase #(.W(W)) u_contador (
        .clk      (clk),
        .clr_i    (reset | (enb & avanzar)),
        .en_i     (enb),
        .cuenta_o (cuenta)
    );

    always_comb begin
        state_d = state_q;
        avanzar = 1'b0;
        case (state_q)
            A_VERDE: begin
                // Max dwell forces the change; the sensor only counts once min dwell is reached.
                if (cuenta == LIM_MAX || (cuenta >= LIM_MIN && sensor_B)) begin
                    state_d = A_AMARILLO;
                    avanzar = 1'b1;
                end
            end
            A_AMARILLO: begin
                if (cuenta == LIM_AM) begin
                    state_d = B_VERDE;
                    avanzar = 1'b1;
                end
            end
            B_VERDE: begin
                if (cuenta == LIM_B) begin
                    state_d = B_AMARILLO;
                    avanzar = 1'b1;
                end
            end
            B_AMARILLO: begin
                if (cuenta == LIM_AM) begin
                    state_d = A_VERDE;
                    avanzar = 1'b1;
                end
            end
            default: begin
                state_d = A_VERDE;
                avanzar = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= A_VERDE;
        end else if (enb) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        semaforo_A = ROJO;
        semaforo_B = ROJO;
        case (state_q)
            A_VERDE:    semaforo_A = VERDE;
            A_AMARILLO: semaforo_A = AMARILLO;
            B_VERDE:    semaforo_B = VERDE;
            B_AMARILLO: semaforo_B = AMARILLO;
            default: begin
                semaforo_A = ROJO;
                semaforo_B = ROJO;
            end
        endcase
    end

    assign fase = state_q;

endmodule

// File: tb/tb_semaforo_vehicular.sv
// tb/tb_semaforo_vehicular.sv - directed and randomized-invariant bench for semaforo_vehicular
module tb_semaforo_vehicular;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic       sensor_B;
    logic [1:0] semaforo_A;
    logic [1:0] semaforo_B;
    logic [1:0] fase;

    int errors = 0;
    int checks = 0;

    semaforo_vehicular dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .sensor_B   (sensor_B),
        .semaforo_A (semaforo_A),
        .semaforo_B (semaforo_B),
        .fase       (fase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic sens);
        reset    = 1'b1;
        enb      = 1'b1;
        sensor_B = sens;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [3:0] luces_esperadas(input int i);
        if (i < 4)       return {2'b10, 2'b00};
        else if (i < 6)  return {2'b01, 2'b00};
        else if (i < 10) return {2'b00, 2'b10};
        else if (i < 12) return {2'b00, 2'b01};
        else             return {2'b10, 2'b00};
    endfunction

    function automatic logic [1:0] fase_esperada(input int i);
        if (i < 4)       return 2'b00;
        else if (i < 6)  return 2'b01;
        else if (i < 10) return 2'b10;
        else if (i < 12) return 2'b11;
        else             return 2'b00;
    endfunction

    initial begin
        logic [1:0] prev_a;
        logic [1:0] prev_b;

        reset    = 1'b1;
        enb      = 1'b1;
        sensor_B = 1'b0;

        // Reset held for 3 cycles with enb high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_A", 8'(semaforo_A), 8'h02);
            check("rst_B", 8'(semaforo_B), 8'h00);
            check("rst_fase", 8'(fase), 8'h00);
            check("rst_cuenta", 8'(dut.cuenta), 8'h00);
        end
        reset = 1'b0;

        // No request: A green for exactly T_VERDE_MAX cycles
        for (int i = 0; i < 8; i++) begin
            check("max_A_green", 8'(semaforo_A), 8'h02);
            tick();
        end
        check("max_A_yellow", 8'(semaforo_A), 8'h01);

        // Request held from release: full 12-cycle loop
        do_reset(1'b1);
        for (int i = 0; i <= 12; i++) begin
            logic [3:0] e;
            e = luces_esperadas(i);
            check("loop_A", 8'(semaforo_A), 8'(e[3:2]));
            check("loop_B", 8'(semaforo_B), 8'(e[1:0]));
            check("loop_fase", 8'(fase), 8'(fase_esperada(i)));
            tick();
        end

        // Late request at cycle 6 of A green
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("late_c6_A", 8'(semaforo_A), 8'h02);
        sensor_B = 1'b1;
        tick();
        check("late_c7_A", 8'(semaforo_A), 8'h01);
        sensor_B = 1'b0;

        // One-cycle pulse before min dwell is not latched
        do_reset(1'b1);
        tick();
        sensor_B = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            check("pulse_A_green", 8'(semaforo_A), 8'h02);
            tick();
        end
        check("pulse_A_yellow", 8'(semaforo_A), 8'h01);

        // Enable freeze in B green at cuenta=1
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) tick();
        check("frz_pre_B", 8'(semaforo_B), 8'h02);
        check("frz_pre_cuenta", 8'(dut.cuenta), 8'h01);
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sensor_B = i[0];
            tick();
            check("frz_B", 8'(semaforo_B), 8'h02);
            check("frz_A", 8'(semaforo_A), 8'h00);
            check("frz_cuenta", 8'(dut.cuenta), 8'h01);
        end
        enb = 1'b1;
        sensor_B = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("frz_rest_B", 8'(semaforo_B), 8'h02);
            tick();
        end
        check("frz_B_yellow", 8'(semaforo_B), 8'h01);
        check("frz_fase", 8'(fase), 8'h03);

        // Reset during B yellow with enb low
        enb   = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_A", 8'(semaforo_A), 8'h02);
        check("mid_rst_B", 8'(semaforo_B), 8'h00);
        check("mid_rst_cuenta", 8'(dut.cuenta), 8'h00);
        check("mid_rst_fase", 8'(fase), 8'h00);
        reset = 1'b0;
        enb   = 1'b1;

        // Randomized sensor/enb run with invariant checks
        prev_a = semaforo_A;
        prev_b = semaforo_B;
        for (int i = 0; i < 400; i++) begin
            logic [1:0] fa;
            sensor_B = 1'($urandom_range(0, 1));
            enb      = ($urandom_range(0, 3) != 0);
            tick();
            check("inv_both", 8'(semaforo_A != 2'b00 && semaforo_B != 2'b00), 8'h00);
            check("inv_A_g2r", 8'(prev_a == 2'b10 && semaforo_A == 2'b00), 8'h00);
            check("inv_B_g2r", 8'(prev_b == 2'b10 && semaforo_B == 2'b00), 8'h00);
            case ({semaforo_A, semaforo_B})
                4'b1000: fa = 2'b00;
                4'b0100: fa = 2'b01;
                4'b0010: fa = 2'b10;
                4'b0001: fa = 2'b11;
                default: fa = ~fase;
            endcase
            check("inv_fase", 8'(fase), 8'(fa));
            prev_a = semaforo_A;
            prev_b = semaforo_B;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
